// File: rtl/sram_latency_shim.sv
// Request/response shim that adds a fixed read latency and a bounded response FIFO in front of a 1-cycle SRAM.
// Optional random grant stalls are enabled by defining SRAM_LATENCY_SHIM_RANDOM_STALL_EN.
module sram_latency_shim #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic                    rvalid_o,
   input  logic                    rready_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   if (LATENCY > 16 || LFSR_SEED == 16'h0) begin : g_param_chk
      $error("sram_latency_shim: LATENCY must be 0..16 and LFSR_SEED non-zero");
   end

   logic [CNT_W-1:0]      r_outst;
   logic                  w_stall;
   logic                  w_acc;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_wr;
   logic                  w_empty;
   logic                  w_full;
   logic [DATA_WIDTH-1:0] w_cap;
   logic [DATA_WIDTH-1:0] w_push_dat;
   logic                  r_vld_p0;
   logic                  r_we_p0;
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [IDX_W-1:0]      w_widx;
   logic [IDX_W-1:0]      w_ridx;
   logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];

`ifdef SRAM_LATENCY_SHIM_RANDOM_STALL_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
   end

   assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
   assign w_stall = 1'b0;
`endif

   // Outstanding count covers pipeline plus FIFO, so a grant always has a FIFO slot waiting for it.
   assign gnt_o       = rst_ni & (r_outst < CNT_W'(FIFO_DEPTH)) & ~w_stall;
   assign w_acc       = req_i & gnt_o;
   assign mem_req_o   = w_acc;
   assign mem_we_o    = we_i;
   assign mem_addr_o  = addr_i;
   assign mem_be_o    = be_i;
   assign mem_wdata_o = wdata_i;

   // Stage p0: request tag travels with the SRAM access
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_vld_p0 <= 1'b0;
         r_we_p0  <= 1'b0;
      end else begin
         r_vld_p0 <= w_acc;
         r_we_p0  <= we_i;
      end
   end

   assign w_cap = r_we_p0 ? '0 : mem_rdata_i;

   // Stage p1..: LATENCY delay registers between SRAM capture and FIFO push
   if (LATENCY == 0) begin : g_no_dly
      assign w_push     = r_vld_p0;
      assign w_push_dat = w_cap;
   end else begin : g_dly
      logic [LATENCY-1:0]    r_vld_p1;
      logic [DATA_WIDTH-1:0] r_dat_p1 [LATENCY];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_vld_p1 <= '0;
         end else begin
            r_vld_p1[0] <= r_vld_p0;
            for (int i = 1; i < int'(LATENCY); i++) r_vld_p1[i] <= r_vld_p1[i-1];
         end
      end

      always_ff @(posedge clk_i) begin
         r_dat_p1[0] <= w_cap;
         for (int i = 1; i < int'(LATENCY); i++) r_dat_p1[i] <= r_dat_p1[i-1];
      end

      assign w_push     = r_vld_p1[LATENCY-1];
      assign w_push_dat = r_dat_p1[LATENCY-1];
   end

   // Response FIFO: registered head, wrap-bit pointers
   assign w_empty  = (r_wptr == r_rptr);
   assign w_full   = ((r_wptr - r_rptr) == PTR_W'(FIFO_DEPTH));
   assign w_wr     = w_push & ~w_full;
   assign w_widx   = IDX_W'(r_wptr % PTR_W'(FIFO_DEPTH));
   assign w_ridx   = IDX_W'(r_rptr % PTR_W'(FIFO_DEPTH));
   assign rvalid_o = ~w_empty;
   assign rdata_o  = w_empty ? '0 : r_fifo[w_ridx];
   assign w_pop    = rvalid_o & rready_i;

   always_ff @(posedge clk_i) begin
      if (w_wr) r_fifo[w_widx] <= w_push_dat;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_outst <= '0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
         if (w_acc & ~w_pop)      r_outst <= r_outst + CNT_W'(1);
         else if (~w_acc & w_pop) r_outst <= r_outst - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_sram_latency_shim.sv
// Directed bench for sram_latency_shim: instance 0 runs LATENCY=2, instance 1 runs LATENCY=0, both FIFO_DEPTH=4.
module tb_sram_latency_shim;

   localparam int DW    = 64;
   localparam int AW    = 64;
   localparam int BW    = DW / 8;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          req    [2];
   logic          we     [2];
   logic          rready [2];
   logic [AW-1:0] addr   [2];
   logic [BW-1:0] be     [2];
   logic [DW-1:0] wdata  [2];
   logic          gnt    [2];
   logic          rvalid [2];
   logic [DW-1:0] rdata  [2];
   logic          pl_en  [2];
   logic [7:0]    pl_idx [2];
   logic [DW-1:0] pl_dat [2];
   bit            tr     [1000];

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   for (genvar k = 0; k < 2; k++) begin : g_inst
      logic          mreq;
      logic          mwe;
      logic [AW-1:0] maddr;
      logic [BW-1:0] mbe;
      logic [DW-1:0] mwdata;
      logic [DW-1:0] mrdata;
      logic [DW-1:0] mem [256];
      logic [DW-1:0] q [$];
      logic [DW-1:0] e;
      int            maxo = 0;
      int            pend = 0;

      sram_latency_shim #(
         .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(k == 0 ? 2 : 0),
         .FIFO_DEPTH(DEPTH), .LFSR_SEED(16'hACE1)
      ) u_dut (
         .clk_i(clk), .rst_ni(rst_n), .req_i(req[k]), .gnt_o(gnt[k]), .we_i(we[k]),
         .addr_i(addr[k]), .be_i(be[k]), .wdata_i(wdata[k]), .rvalid_o(rvalid[k]),
         .rready_i(rready[k]), .rdata_o(rdata[k]), .mem_req_o(mreq), .mem_we_o(mwe),
         .mem_addr_o(maddr), .mem_be_o(mbe), .mem_wdata_o(mwdata), .mem_rdata_i(mrdata)
      );

      // SRAM model: one-cycle read, byte-enabled write, garbage on the read bus after writes
      always @(posedge clk) begin
         if (pl_en[k]) mem[pl_idx[k]] <= pl_dat[k];
         if (mreq) begin
            if (mwe) begin
               for (int b = 0; b < BW; b++)
                  if (mbe[b]) mem[maddr[10:3]][b*8 +: 8] <= mwdata[b*8 +: 8];
               mrdata <= 64'hBAD0_BAD0_BAD0_BAD0;
            end else begin
               mrdata <= mem[maddr[10:3]];
            end
         end
      end

      // In-order scoreboard fed by accepted requests, drained by popped responses
      always @(negedge clk) begin
         if (!rst_n) begin
            q.delete();
            pend = 0;
         end else begin
            if (rvalid[k] && rready[k]) begin
               if (q.size() == 0) check("spurious_rvalid", 1, 0);
               else begin
                  e = q.pop_front();
                  check("sb_rdata", rdata[k], e);
               end
            end
            if (mreq) q.push_back(mwe ? 64'h0 : mem[maddr[10:3]]);
            pend = q.size();
            if (pend > maxo) maxo = pend;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pl(input int k, input logic [7:0] idx, input logic [63:0] d);
      pl_en[k] = 1'b1; pl_idx[k] = idx; pl_dat[k] = d;
      cyc();
      pl_en[k] = 1'b0;
   endtask

   task automatic issue(input int k, input logic w, input logic [63:0] a,
                        input logic [7:0] b, input logic [63:0] d);
      int n = 0;
      req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
      @(negedge clk);
      while (!gnt[k] && n < 50) begin
         cyc();
         @(negedge clk);
         n++;
      end
      if (!gnt[k]) check("gnt_timeout", 0, 1);
      cyc();
   endtask

   task automatic idle(input int k);
      req[k] = 1'b0;
      we[k]  = 1'b0;
   endtask

   task automatic wait_resp(input int k, output logic [63:0] d);
      int n = 0;
      @(negedge clk);
      while (!(rvalid[k] && rready[k]) && n < 40) begin
         cyc();
         @(negedge clk);
         n++;
      end
      if (!(rvalid[k] && rready[k])) begin
         check("resp_timeout", 0, 1);
         d = '0;
      end else begin
         d = rdata[k];
      end
      cyc();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic stall_run(input bit rec, output int low, output int diff);
      low = 0; diff = 0;
      rready[1] = 1'b1; we[1] = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         req[1]  = 1'b1;
         addr[1] = 64'((c % 8) * 8);
         @(negedge clk);
         if (!gnt[1]) low++;
         if (rec) tr[c] = gnt[1];
         else if (tr[c] != gnt[1]) diff++;
         cyc();
      end
      idle(1);
      repeat (10) cyc();
   endtask

   initial begin
      logic [63:0] d;
      int cnt, nr, low, diff;

      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req[k] = 1'b0; we[k] = 1'b0; rready[k] = 1'b0; addr[k] = '0;
         be[k] = '0; wdata[k] = '0; pl_en[k] = 1'b0; pl_idx[k] = '0; pl_dat[k] = '0;
      end
      repeat (2) cyc();
      pl(0, 8'd16, 64'hDEAD_BEEF_0123_4567);
      pl(0, 8'd17, 64'h0BAD_F00D_1234_5678);
      pl(0, 8'd32, 64'h0);
      for (int i = 0; i < 8; i++) pl(1, 8'(i), 64'hA5A5_0000_0000_0000 | 64'(i));

      // Reset state, with a request pending
      req[0] = 1'b1; addr[0] = 64'h80;
      @(negedge clk);
      check("rst_gnt0", gnt[0], 0);
      check("rst_gnt1", gnt[1], 0);
      check("rst_memreq", g_inst[0].mreq, 0);
      check("rst_rvalid", rvalid[0], 0);
      check("rst_rdata", rdata[0], 0);
      idle(0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("rel_gnt", gnt[0], 1);

`ifndef SRAM_LATENCY_SHIM_RANDOM_STALL_EN
      // Read latency: grant at T, response only at T+4
      cyc();
      rready[0] = 1'b1;
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 64'h80;
      @(negedge clk);
      check("lat_gnt", gnt[0], 1);
      for (int i = 1; i <= 5; i++) begin
         cyc();
         idle(0);
         @(negedge clk);
         check($sformatf("lat_rvalid_T%0d", i), rvalid[0], (i == 4) ? 1 : 0);
         if (i == 4) check("lat_rdata", rdata[0], 64'hDEAD_BEEF_0123_4567);
      end
      cyc();

      // Write then read same address, responses in order
      issue(0, 1'b1, 64'h100, 8'h0F, 64'h1122_3344_5566_7788);
      issue(0, 1'b0, 64'h100, 8'h00, 64'h0);
      idle(0);
      wait_resp(0, d);
      check("wr_resp_rdata", d, 64'h0);
      wait_resp(0, d);
      check("raw_rdata", d, 64'h0000_0000_5566_7788);
      repeat (3) cyc();

      // Backpressure: four grants then stall, pop releases one grant a cycle later
      rready[0] = 1'b0;
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 64'h80;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (gnt[0]) cnt++;
         cyc();
      end
      check("bp_grants", cnt, 4);
      @(negedge clk);
      check("bp_gnt_full", gnt[0], 0);
      check("bp_rvalid_full", rvalid[0], 1);
      cyc();
      rready[0] = 1'b1;
      @(negedge clk);
      check("bp_gnt_pop_cycle", gnt[0], 0);
      check("bp_rvalid_pop", rvalid[0], 1);
      cyc();
      rready[0] = 1'b0;
      @(negedge clk);
      check("bp_gnt_after_pop", gnt[0], 1);
      cyc();
      idle(0);
      rready[0] = 1'b1;
      repeat (12) cyc();

      // LATENCY=0: eight back-to-back reads
      rready[1] = 1'b1;
      nr = 0;
      for (int c = 0; c < 12; c++) begin
         req[1] = (c < 8); we[1] = 1'b0; addr[1] = 64'(c * 8);
         @(negedge clk);
         if (c < 8) check("b2b_gnt", gnt[1], 1);
         if (rvalid[1]) begin
            check("b2b_rdata", rdata[1], 64'hA5A5_0000_0000_0000 | 64'(nr));
            check("b2b_cycle", c, nr + 2);
            nr++;
         end
         cyc();
      end
      idle(1);
      check("b2b_count", nr, 8);

      // Reset with three responses buffered
      rready[0] = 1'b0;
      issue(0, 1'b0, 64'h80, 8'h00, 64'h0);
      issue(0, 1'b0, 64'h88, 8'h00, 64'h0);
      issue(0, 1'b0, 64'h80, 8'h00, 64'h0);
      idle(0);
      repeat (6) cyc();
      @(negedge clk);
      check("mid_rvalid_before", rvalid[0], 1);
      cyc();
      rst_n = 1'b0;
      #1;
      check("mid_rvalid_rst", rvalid[0], 0);
      check("mid_rdata_rst", rdata[0], 0);
      check("mid_gnt_rst", gnt[0], 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("mid_gnt_rel", gnt[0], 1);
      rready[0] = 1'b1;
      cyc();
      issue(0, 1'b0, 64'h88, 8'h00, 64'h0);
      idle(0);
      wait_resp(0, d);
      check("mid_new_rdata", d, 64'h0BAD_F00D_1234_5678);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rvalid[0]) cnt++;
         cyc();
      end
      check("mid_no_stale", cnt, 0);
      check("max_outst0", g_inst[0].maxo, DEPTH);
`else
      // Random stalls: grant duty and reproducibility
      do_reset();
      stall_run(1'b1, low, diff);
      check("stall_low_in_range", (low >= 200 && low <= 300) ? 1 : 0, 1);
      do_reset();
      stall_run(1'b0, low, diff);
      check("stall_trace_repeat", diff, 0);
`endif

      repeat (5) cyc();
      check("sb_pend0", g_inst[0].pend, 0);
      check("sb_pend1", g_inst[1].pend, 0);
      check("max_outst_bound", (g_inst[0].maxo <= DEPTH && g_inst[1].maxo <= DEPTH) ? 1 : 0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/sram_latency_shim.md
Name: sram_latency_shim

Overview:
- Sits between the AXI-to-memory bridge and the SRAM model in the simulation harness.
- Converts the bridge's simple memory request interface into a req/gnt/rvalid/rready protocol.
- Adds a configurable fixed response latency and a bounded response buffer with backpressure.
- Lets benches exercise the core under realistic DRAM-like latency without modifying the SRAM.

Parameters:
DATA_WIDTH, 64, data bus width in bits (multiple of 8)
ADDR_WIDTH, 64, request address width
LATENCY, 2, extra response delay stages after the SRAM's 1-cycle read (0..16)
FIFO_DEPTH, 4, response buffer entries and max outstanding requests (power of two, 1..32)
LFSR_SEED, 16'hACE1, non-zero seed for the random-stall LFSR (optional feature only)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  upstream request valid
gnt_o  out  1  request accepted this cycle when req_i&gnt_o
we_i  in  1  1=write, 0=read
addr_i  in  ADDR_WIDTH  byte address
be_i  in  DATA_WIDTH/8  byte enables (writes)
wdata_i  in  DATA_WIDTH  write data
rvalid_o  out  1  response valid
rready_i  in  1  upstream accepts response
rdata_o  out  DATA_WIDTH  read data (don't-care for write responses; driven 0)
mem_req_o  out  1  SRAM request
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  ADDR_WIDTH  SRAM address (pass-through)
mem_be_o  out  DATA_WIDTH/8  SRAM byte enables
mem_wdata_o  out  DATA_WIDTH  SRAM write data
mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid 1 cycle after mem_req_o

Behaviour:
- Reset: gnt_o=0 while rst_ni low, then per rule below; rvalid_o=0, rdata_o=0, mem_req_o=0; outstanding counter=0, FIFO empty, pipeline valids cleared, LFSR=LFSR_SEED.
- Reset mid-operation discards all in-flight and buffered responses. SRAM contents are not affected.
- Grant: gnt_o = (outstanding < FIFO_DEPTH) & ~stall. It is computed from registered state only; there is no combinational path from rready_i or req_i to gnt_o.
- Issue: mem_req_o = req_i & gnt_o, combinational. mem_we/addr/be/wdata pass through from the inputs.
- Every accepted request, read or write, produces exactly one response, in acceptance order.
- Pipeline:
  - Grant cycle T: tag = {valid=1, we}.
  - T+1: mem_rdata_i captured (zeroed for writes).
  - Then LATENCY register stages; output written to the FIFO at end of cycle T+1+LATENCY.
- FIFO: registered, no fall-through. rvalid_o first asserts in cycle T+LATENCY+2 if the FIFO was empty.
- rvalid_o/rdata_o hold stable until rvalid_o&rready_i. The pop advances the head next cycle; back-to-back pops give one response per cycle.
- Outstanding counter (width $clog2(FIFO_DEPTH+1)):
  - +1 on grant, −1 on pop; unchanged when both happen in the same cycle.
  - It counts pipeline plus FIFO entries, so the FIFO can never overflow. A push into a full FIFO is impossible; the bench asserts this.
- At outstanding==FIFO_DEPTH with a pop in the same cycle, gnt_o stays 0 this cycle and rises next cycle.
- Pointers: log2(FIFO_DEPTH)+1 bits with a wrap bit. Full/empty derived from pointer compare.
- Read-after-write to the same address in consecutive grants returns the new data, because the SRAM orders them.

Optional Feature:
- Macro SRAM_LATENCY_SHIM_RANDOM_STALL_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle out of reset.
  - stall = (lfsr[1:0]==2'b00), giving ~25% cycles with gnt_o forced 0.
  - Sequence is deterministic from LFSR_SEED.
- Undefined: stall tied 0, no LFSR logic; grant depends only on the outstanding count.

Test Plan:
- LATENCY=2, read addr 0x80 (SRAM preloaded 64'hDEAD_BEEF_0123_4567) granted at cycle T, rready_i=1 -> rvalid_o=1 only at T+4, rdata_o=64'hDEAD_BEEF_0123_4567.
- Write 64'h1122_3344_5566_7788 be=8'h0F to 0x100, then read 0x100 (old 0) -> write response rdata 0; read returns 64'h0000_0000_5566_7788, in order.
- rready_i=0, req_i=1 continuous, FIFO_DEPTH=4 -> exactly 4 grants then gnt_o=0. Raise rready_i for 1 cycle -> one pop, gnt_o=1 the following cycle, never the same cycle.
- 8 back-to-back reads with rready_i=1, LATENCY=0 -> 8 consecutive rvalid cycles starting T+2, data in address order, gnt_o never drops.
- Assert rst_ni low with 3 requests outstanding -> rvalid_o=0 immediately; after release gnt_o=1, first new read returns correct data, no stale responses.
- Macro defined, LFSR_SEED=16'hACE1, req_i=1 for 1000 cycles, rready_i=1 -> gnt_o low on 200–300 cycles, all responses correct and ordered; identical grant trace on rerun.
